// File: rtl/mem_stage_hs.sv
// Memory-access pipeline stage between execute and writeback.
// Three access classes:
//   none : retires on the next edge.
//   io   : hits the local I/O register and retires on the next edge.
//   mem  : latched into holding registers, then issued over a req/ready
//          handshake; upstream is stalled until the memory completes.
// Results leave through a registered writeback bundle.
module mem_stage_hs #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 16,
    parameter int                RD_W    = 3,
    parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] b,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              regwrite,
    input  logic [RD_W-1:0]   rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_regwrite
);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t            state_reg;

    // Holding registers for the outstanding memory access
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              regwrite_reg;

    // Registered writeback bundle and I/O register
    logic              wb_valid_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic [RD_W-1:0]   wb_rd_reg;
    logic              wb_regwrite_reg;
    logic [DATA_W-1:0] io_out_reg;

    // Access-class decode; a simultaneous read and write counts as a store
    logic access;
    logic is_io;
    logic is_mem;

    assign access = memread | memwrite;
    assign is_io  = access && (aluout[ADDR_W-1:0] == IO_ADDR);
    assign is_mem = access && !is_io;

    // Stall: raised on the accept cycle of a memory access and while waiting
    // for mem_ready; held low during reset so upstream is never frozen.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            case (state_reg)
                IDLE:    stall = in_valid && is_mem;
                BUSY:    stall = !mem_ready;
                default: stall = 1'b0;
            endcase
        end
    end

    // Request bundle comes straight from registers, so it stays stable while
    // the memory inserts wait states.
    assign mem_req     = (state_reg == BUSY);
    assign mem_we      = we_reg;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;

    assign io_out      = io_out_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_data     = wb_data_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_regwrite = wb_regwrite_reg;

    // Stage FSM: accepts instructions in IDLE, waits out the handshake in BUSY,
    // and produces the registered writeback pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            we_reg          <= 1'b0;
            rd_reg          <= '0;
            regwrite_reg    <= 1'b0;
            wb_valid_reg    <= 1'b0;
            wb_data_reg     <= '0;
            wb_rd_reg       <= '0;
            wb_regwrite_reg <= 1'b0;
            io_out_reg      <= '0;
        end else begin
            // Pulse-style strobes default low; data and rd hold their value
            wb_valid_reg    <= 1'b0;
            wb_regwrite_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mem) begin
                            addr_reg     <= aluout[ADDR_W-1:0];
                            wdata_reg    <= b;
                            we_reg       <= memwrite;
                            rd_reg       <= rd;
                            regwrite_reg <= regwrite;
                            state_reg    <= BUSY;
                        end else begin
                            wb_valid_reg <= 1'b1;
                            wb_rd_reg    <= rd;
                            if (is_io && memwrite) begin
                                io_out_reg      <= b;
                                wb_data_reg     <= aluout;
                                wb_regwrite_reg <= 1'b0;
                            end else if (is_io) begin
                                wb_data_reg     <= io_in;
                                wb_regwrite_reg <= regwrite;
                            end else begin
                                wb_data_reg     <= aluout;
                                wb_regwrite_reg <= regwrite;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= rd_reg;
                        if (we_reg) begin
                            wb_data_reg     <= DATA_W'(addr_reg);
                            wb_regwrite_reg <= 1'b0;
                        end else begin
                            wb_data_reg     <= mem_rdata;
                            wb_regwrite_reg <= regwrite_reg;
                        end
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
